// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: frame header, loader states and shared imem address width
package imem_loader_pkg;
  localparam logic [7:0] HDR = 8'hA5;
  localparam int IMEM_AW_DEF = 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream to imem words; holds core in reset until checksum verifies
// Ports: Clk/Rst (async high); RxData/RxValid/RxReady byte handshake;
// ImemWrAddr/ImemWrData/ImemWrite imem write port; CpuRst core hold; Done/Error frame status.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_AW = IMEM_AW_DEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady,
  output logic [31:0] ImemWrAddr,
  output logic [31:0] ImemWrData,
  output logic        ImemWrite,
  output logic        CpuRst,
  output logic        Done,
  output logic        Error
);
  localparam logic [16:0] LEN_MAX = 17'(1) << IMEM_AW;
  state_e state_q, state_d;
  logic [31:0] word_q, word_d, addr_q, addr_d, data_q, data_d;
  logic [1:0] bidx_q, bidx_d;
  logic [IMEM_AW:0] widx_q, widx_d, len_q, len_d, widx_n;
  logic [7:0] lenhi_q, lenhi_d, csum_q, csum_d;
  logic wr_q, wr_d, rdy_q;
  logic acc;
  logic [16:0] len_rx;
  logic [31:0] word_n;
  // ready drops for the strobe cycle so only one byte is in flight per write
  assign RxReady = rdy_q & ~wr_q;
  assign acc = RxValid & RxReady;
  assign len_rx = {1'b0, lenhi_q, RxData};
  assign widx_n = widx_q + 1'b1;
  assign word_n = {word_q[23:0], RxData};
  assign ImemWrAddr = addr_q;
  assign ImemWrData = data_q;
  assign ImemWrite = wr_q;
  assign Done = state_q == S_DONE;
  assign Error = state_q == S_ERR;
  assign CpuRst = state_q != S_DONE;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      bidx_q  <= '0;
      widx_q  <= '0;
      len_q   <= '0;
      lenhi_q <= '0;
      csum_q  <= '0;
      wr_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      bidx_q  <= bidx_d;
      widx_q  <= widx_d;
      len_q   <= len_d;
      lenhi_q <= lenhi_d;
      csum_q  <= csum_d;
      wr_q    <= wr_d;
      rdy_q   <= 1'b1;
    end
  end
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    addr_d  = addr_q;
    data_d  = data_q;
    bidx_d  = bidx_q;
    widx_d  = widx_q;
    len_d   = len_q;
    lenhi_d = lenhi_q;
    csum_d  = csum_q;
    wr_d    = 1'b0;
    if (acc) begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (RxData == HDR) begin
            state_d = S_LEN_HI;
            widx_d  = '0;
            bidx_d  = '0;
            csum_d  = '0;
          end
        end
        S_LEN_HI: begin
          lenhi_d = RxData;
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          state_d = (len_rx == '0 || len_rx > LEN_MAX) ? S_ERR : S_DATA;
          len_d   = (IMEM_AW+1)'(len_rx);
        end
        S_DATA: begin
          word_d = word_n;
          csum_d = csum_q ^ RxData;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            wr_d    = 1'b1;
            addr_d  = 32'(widx_q[IMEM_AW-1:0]) << 2;
            data_d  = word_n;
            widx_d  = widx_n;
            state_d = (widx_n == len_q) ? S_CSUM : S_DATA;
          end
        end
        S_CSUM: state_d = (RxData == csum_q) ? S_DONE : S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames against default and IMEM_AW=2 loaders
module tb_imem_loader;
  logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, sel = 1'b0, gaps = 1'b0;
  logic [7:0] rx_data = '0;
  logic rdy0, wr0, crst0, done0, err0, rdy1, wr1, crst1, done1, err1;
  logic [31:0] addr0, data0, addr1, data1;
  logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];
  logic [7:0] frm[$];
  int ntot = 0, npass = 0;
  always #5 clk = ~clk;
  imem_loader u0 (
    .Clk(clk), .Rst(rst), .RxData(rx_data), .RxValid(rx_valid & ~sel), .RxReady(rdy0),
    .ImemWrAddr(addr0), .ImemWrData(data0), .ImemWrite(wr0),
    .CpuRst(crst0), .Done(done0), .Error(err0)
  );
  imem_loader #(.IMEM_AW(2)) u1 (
    .Clk(clk), .Rst(rst), .RxData(rx_data), .RxValid(rx_valid & sel), .RxReady(rdy1),
    .ImemWrAddr(addr1), .ImemWrData(data1), .ImemWrite(wr1),
    .CpuRst(crst1), .Done(done1), .Error(err1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  always @(negedge clk) begin
    if (!rst && wr0) begin
      wa0.push_back(addr0);
      wd0.push_back(data0);
      chk("rdy0_on_wr", 32'(rdy0), 0);
    end
    if (!rst && wr1) begin
      wa1.push_back(addr1);
      wd1.push_back(data1);
      chk("rdy1_on_wr", 32'(rdy1), 0);
    end
  end
  task automatic send(input logic [7:0] b);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    while (!(sel ? rdy1 : rdy0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("ready_timeout", 32'(n), 0);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask
  task automatic send_frm();
    foreach (frm[i]) send(frm[i]);
  endtask
  task automatic chk_basic(input string tag);
    chk({tag, "_nwr"}, 32'(wa0.size()), 2);
    if (wa0.size() == 2) begin
      chk({tag, "_a0"}, wa0[0], 32'h0);
      chk({tag, "_d0"}, wd0[0], 32'h2008_0005);
      chk({tag, "_a1"}, wa0[1], 32'h4);
      chk({tag, "_d1"}, wd0[1], 32'h0);
    end
    chk({tag, "_done"}, 32'(done0), 1);
    chk({tag, "_cpurst"}, 32'(crst0), 0);
    chk({tag, "_err"}, 32'(err0), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog ntot=%0d", ntot);
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(rdy0), 0);
    chk("rst_wr", 32'(wr0), 0);
    chk("rst_addr", addr0, 0);
    chk("rst_data", data0, 0);
    chk("rst_cpurst", 32'(crst0), 1);
    chk("rst_done", 32'(done0), 0);
    chk("rst_err", 32'(err0), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", 32'(rdy0), 1);
    frm = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
    send_frm();
    chk_basic("basic");
    wa0.delete(); wd0.delete();
    frm[11] = 8'h2C;
    send_frm();
    chk("badcs_nwr", 32'(wa0.size()), 2);
    chk("badcs_err", 32'(err0), 1);
    chk("badcs_done", 32'(done0), 0);
    chk("badcs_cpurst", 32'(crst0), 1);
    wa0.delete(); wd0.delete();
    frm[11] = 8'h2D;
    send_frm();
    chk_basic("recover");
    wa0.delete(); wd0.delete();
    frm = '{8'hA5, 8'h00, 8'h00};
    send_frm();
    @(negedge clk);
    chk("len0_err", 32'(err0), 1);
    chk("len0_nwr", 32'(wa0.size()), 0);
    sel = 1'b1;
    frm = '{8'hA5, 8'h00, 8'h05};
    send_frm();
    chk("len5_err", 32'(err1), 1);
    frm = '{8'hA5, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'hF4};
    send_frm();
    chk("len4_nwr", 32'(wa1.size()), 4);
    if (wa1.size() == 4) begin
      chk("len4_a0", wa1[0], 32'h0);
      chk("len4_d0", wd1[0], 32'h0102_0304);
      chk("len4_alast", wa1[3], 32'hC);
      chk("len4_dlast", wd1[3], 32'h0000_00F0);
    end
    chk("len4_done", 32'(done1), 1);
    chk("len4_err", 32'(err1), 0);
    sel = 1'b0;
    gaps = 1'b1;
    frm = '{8'h11, 8'h22, 8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
    send_frm();
    chk_basic("junk");
    gaps = 1'b0;
    wa0.delete(); wd0.delete();
    frm = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00};
    send_frm();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rdy", 32'(rdy0), 0);
    chk("mid_wr", 32'(wr0), 0);
    chk("mid_addr", addr0, 0);
    chk("mid_data", data0, 0);
    chk("mid_cpurst", 32'(crst0), 1);
    chk("mid_done", 32'(done0), 0);
    chk("mid_err", 32'(err0), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_nwr", 32'(wa0.size()), 1);
    wa0.delete(); wd0.delete();
    frm = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
    send_frm();
    chk_basic("after_rst");
    wa0.delete(); wd0.delete();
    send(8'hA5);
    chk("reload_cpurst", 32'(crst0), 1);
    chk("reload_done", 32'(done0), 0);
    frm = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h2A};
    send_frm();
    chk("reload_nwr", 32'(wa0.size()), 2);
    if (wa0.size() == 2) begin
      chk("reload_a0", wa0[0], 32'h0);
      chk("reload_d0", wd0[0], 32'hDEAD_BEEF);
      chk("reload_a1", wa0[1], 32'h4);
      chk("reload_d1", wd0[1], 32'h1234_5678);
    end
    chk("reload_done2", 32'(done0), 1);
    chk("reload_cpurst2", 32'(crst0), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
